note_hit_judge: RTL

//  Upstream stage of the game controller FSM. Decides, per lane, whether a player's

---
 rtl/gh_pkg.sv | 18 +
 rtl/lane_judge.sv | 92 +++++++++
 rtl/note_hit_judge.sv | 101 ++++++++++
 3 files changed

// File: rtl/gh_pkg.sv
// Shared game-controller definitions: lane FSM states and default sizing.
package gh_pkg;

    typedef enum logic {
        LANE_IDLE,
        LANE_ARMED
    } lane_state_t;

    localparam int DEF_LANES   = 4;
    localparam int DEF_WIN_CYC = 8;
    localparam int DEF_CW      = 8;

    // Width of a down-counter that must hold WIN_CYC-1 (WIN_CYC >= 2).
    function automatic int cnt_width(input int win);
        return (win <= 2) ? 1 : $clog2(win);
    endfunction

endpackage

// File: rtl/lane_judge.sv
// One note lane: fret edge detect, IDLE/ARMED judge FSM and hit-window counter.
// hit/miss are combinational strobes for the current cycle; the top registers them.
module lane_judge
    import gh_pkg::*;
#(
    parameter int WIN_CYC    = DEF_WIN_CYC,
    parameter bit GHOST_MISS = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    input  logic beg,
    input  logic note_arrive,
    input  logic btn,
    output logic hit,
    output logic miss
);

    localparam int CNT_W = cnt_width(WIN_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIN_CYC - 1);

    lane_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;
    logic             press;

    // Next state, window count and judge strobes; pause holds everything.
    always_comb begin
        btn_d   = btn;              // tracks even while paused, so paused edges are lost
        press   = btn & ~btn_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        hit     = 1'b0;
        miss    = 1'b0;
        if (!pause) begin
            if (!beg) begin
                state_d = LANE_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    LANE_IDLE: begin
                        if (note_arrive) begin
                            // a press on the arrival cycle itself is an immediate hit
                            if (press) begin
                                hit = 1'b1;
                            end else begin
                                state_d = LANE_ARMED;
                                cnt_d   = CNT_LOAD;
                            end
                        end else if (press && GHOST_MISS) begin
                            miss = 1'b1;
                        end
                    end
                    LANE_ARMED: begin
                        // the pending note is always judged before a new arrival re-arms
                        if (press)
                            hit = 1'b1;
                        else if (cnt_q == '0 || note_arrive)
                            miss = 1'b1;
                        if (note_arrive) begin
                            state_d = LANE_ARMED;
                            cnt_d   = CNT_LOAD;
                        end else if (press || cnt_q == '0) begin
                            state_d = LANE_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d = LANE_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LANE_IDLE;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
        end
    end

endmodule

// File: rtl/note_hit_judge.sv
// Per-lane hit/miss judging with registered comp/miss pulses and a saturating combo.
module note_hit_judge
    import gh_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int WIN_CYC    = DEF_WIN_CYC,
    parameter int CW         = DEF_CW,
    parameter bit GHOST_MISS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             beg,
    input  logic [LANES-1:0] note_arrive,
    input  logic [LANES-1:0] btn,
    output logic             comp,
    output logic             miss,
    output logic [LANES-1:0] hit_lane,
    output logic [CW-1:0]    combo
);

    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = CW + PC_W;

    logic [LANES-1:0] hit_vec, miss_vec;
    logic [PC_W-1:0]  hit_cnt;
    logic [SUM_W-1:0] combo_sum;

    logic             comp_q, comp_d;
    logic             miss_q, miss_d;
    logic [LANES-1:0] hit_lane_q, hit_lane_d;
    logic [CW-1:0]    combo_q, combo_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_judge #(
            .WIN_CYC    (WIN_CYC),
            .GHOST_MISS (GHOST_MISS)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .pause       (pause),
            .beg         (beg),
            .note_arrive (note_arrive[i]),
            .btn         (btn[i]),
            .hit         (hit_vec[i]),
            .miss        (miss_vec[i])
        );
    end

    // Number of lanes hit this cycle.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LANES; i++)
            hit_cnt = hit_cnt + PC_W'(hit_vec[i]);
    end

    // Output pulses and combo update; any miss clears combo and its hits are not counted.
    always_comb begin
        comp_d     = 1'b0;
        miss_d     = 1'b0;
        hit_lane_d = '0;
        combo_d    = combo_q;
        combo_sum  = SUM_W'(combo_q) + SUM_W'(hit_cnt);
        if (!pause) begin
            if (!beg) begin
                combo_d = '0;
            end else begin
                comp_d     = |hit_vec;
                miss_d     = |miss_vec;
                hit_lane_d = hit_vec;
                if (|miss_vec)
                    combo_d = '0;
                else if (combo_sum > SUM_W'({CW{1'b1}}))
                    combo_d = '1;
                else
                    combo_d = combo_sum[CW-1:0];
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_q     <= 1'b0;
            miss_q     <= 1'b0;
            hit_lane_q <= '0;
            combo_q    <= '0;
        end else begin
            comp_q     <= comp_d;
            miss_q     <= miss_d;
            hit_lane_q <= hit_lane_d;
            combo_q    <= combo_d;
        end
    end

    assign comp     = comp_q;
    assign miss     = miss_q;
    assign hit_lane = hit_lane_q;
    assign combo    = combo_q;

endmodule
